// File: rtl/jls_pkg.sv
// rtl/jls_pkg.sv - shared constants and FSM encoding for the JPEG-LS stream feeder
package jls_pkg;

    localparam int JLS_MIN_WIDTH  = 4;
    localparam int JLS_NEW_CYCLES = 368;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        STREAM,
        PAD,
        DISCARD,
        DONE
    } feeder_state_t;

endpackage

// File: rtl/jls_lane_serializer.sv
// rtl/jls_lane_serializer.sv - holds one input beat and hands out its used lanes one per clock
module jls_lane_serializer #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [2:0]                   used,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [CHANNELS*DATA_W-1:0]   s_data,
    output logic                         take,
    output logic                         pix_valid,
    output logic [DATA_W-1:0]            pix_data,
    output logic                         last_load
);

    logic [CHANNELS*DATA_W-1:0] beat_q, beat_d;
    logic [2:0]                 pending_q, pending_d;

    // Lane 0 goes straight out on acceptance; the register only keeps the lanes still owed.
    assign s_ready = en && (pending_q == 3'd0);
    assign take    = s_valid && s_ready;

    always_comb begin
        beat_d    = beat_q;
        pending_d = pending_q;
        pix_valid = 1'b0;
        pix_data  = '0;
        last_load = 1'b0;
        if (take) begin
            pix_valid = 1'b1;
            pix_data  = s_data[DATA_W-1:0];
            beat_d    = s_data >> DATA_W;
            pending_d = used - 3'd1;
            last_load = (used == 3'd1);
        end else if (pending_q != 3'd0) begin
            pix_valid = 1'b1;
            pix_data  = beat_q[DATA_W-1:0];
            beat_d    = beat_q >> DATA_W;
            pending_d = pending_q - 3'd1;
            last_load = (pending_q == 3'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q    <= '0;
            pending_q <= '0;
        end else begin
            beat_q    <= beat_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/jls_stream_feeder.sv
// rtl/jls_stream_feeder.sv - turns a ready/valid pixel stream into the jls_encoder inew/ivalid/idata sequence
module jls_stream_feeder
    import jls_pkg::*;
#(
    parameter int MAXLEN_LEVEL = 12,
    parameter int DATA_W       = 8,
    parameter int CHANNELS     = 1,
    parameter int NEW_CYCLES   = JLS_NEW_CYCLES
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [MAXLEN_LEVEL-1:0]      cfg_width,
    input  logic [15:0]                  cfg_height,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [CHANNELS*DATA_W-1:0]   s_data,
    input  logic                         s_last,
    output logic                         busy,
    output logic                         inew,
    output logic                         ivalid,
    output logic [DATA_W-1:0]            idata,
    output logic                         frame_done,
    output logic                         err_cfg,
    output logic                         err_short,
    output logic                         err_long
);

    localparam int PW = (NEW_CYCLES > 1) ? $clog2(NEW_CYCLES) : 1;
    localparam int L  = MAXLEN_LEVEL;

    feeder_state_t state_q, state_d;
    logic [L-1:0]  width_q, width_d, col_q, col_d;
    logic [15:0]   height_q, height_d, row_q, row_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          final_out_q, final_out_d;
    logic          tag_short_q, tag_short_d, tag_long_q, tag_long_d, tag_fin_q, tag_fin_d;
    logic          busy_q, busy_d, inew_q, inew_d, ivalid_q, ivalid_d, frame_done_q, frame_done_d;
    logic          err_cfg_q, err_cfg_d, err_short_q, err_short_d, err_long_q, err_long_d;
    logic [DATA_W-1:0] idata_q, idata_d;

    logic          ser_en, ser_ready, take, ser_valid, ser_last;
    logic [DATA_W-1:0] ser_data;
    logic [2:0]    used;
    logic [L:0]    col_adv, col_wrap;
    logic          last_row, beat_final, at_final;

    // The cursor (col/row) tracks the next pixel position to be accepted, not issued.
    assign col_adv    = {1'b0, col_q} + (L+1)'(CHANNELS);
    assign col_wrap   = col_adv - {1'b0, width_q};
    assign last_row   = (row_q == height_q - 16'd1);
    assign beat_final = last_row && (col_adv >= {1'b0, width_q});
    assign at_final   = last_row && (col_q == width_q - 1'b1);
    assign used       = beat_final ? 3'(width_q - col_q) : 3'(CHANNELS);
    assign ser_en     = (state_q == STREAM) && !final_out_q;
    assign s_ready    = ser_ready || (state_q == DISCARD);

    jls_lane_serializer #(
        .DATA_W   (DATA_W),
        .CHANNELS (CHANNELS)
    ) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (ser_en),
        .used      (used),
        .s_valid   (s_valid),
        .s_ready   (ser_ready),
        .s_data    (s_data),
        .take      (take),
        .pix_valid (ser_valid),
        .pix_data  (ser_data),
        .last_load (ser_last)
    );

    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        height_d    = height_q;
        col_d       = col_q;
        row_d       = row_q;
        pre_d       = pre_q;
        final_out_d = final_out_q;
        tag_short_d = tag_short_q;
        tag_long_d  = tag_long_q;
        tag_fin_d   = tag_fin_q;
        ivalid_d    = 1'b0;
        idata_d     = '0;
        err_cfg_d   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                if (cfg_width < L'(JLS_MIN_WIDTH) || cfg_height == 16'd0) begin
                    err_cfg_d = 1'b1;
                end else begin
                    width_d     = cfg_width;
                    height_d    = cfg_height;
                    col_d       = '0;
                    row_d       = '0;
                    pre_d       = '0;
                    final_out_d = 1'b0;
                    state_d     = PREAMBLE;
                end
            end
            PREAMBLE: begin
                if (pre_q == PW'(NEW_CYCLES - 1)) state_d = STREAM;
                else                              pre_d   = pre_q + 1'b1;
            end
            STREAM: begin
                if (final_out_q) begin
                    state_d = DONE;
                end else begin
                    if (take) begin
                        tag_short_d = s_last && !beat_final;
                        tag_long_d  = beat_final && !s_last;
                        tag_fin_d   = beat_final && s_last;
                        if (col_adv >= {1'b0, width_q}) begin
                            col_d = col_wrap[L-1:0];
                            row_d = row_q + 16'd1;
                        end else begin
                            col_d = col_adv[L-1:0];
                        end
                    end
                    ivalid_d = ser_valid;
                    idata_d  = ser_data;
                    if (ser_last) begin
                        if (tag_short_d)      state_d     = PAD;
                        else if (tag_long_d)  state_d     = DISCARD;
                        else if (tag_fin_d)   final_out_d = 1'b1;
                    end
                end
            end
            PAD: begin
                if (final_out_q) begin
                    state_d = DONE;
                end else begin
                    ivalid_d = 1'b1;
                    if (at_final) begin
                        final_out_d = 1'b1;
                    end else if (col_q == width_q - 1'b1) begin
                        col_d = '0;
                        row_d = row_q + 16'd1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DISCARD: if (s_valid && s_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        inew_d       = (state_d == PREAMBLE);
        busy_d       = (state_d != IDLE);
        frame_done_d = (state_d == DONE);
        err_short_d  = take && s_last && !beat_final;
        err_long_d   = take && beat_final && !s_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            width_q      <= '0;
            height_q     <= '0;
            col_q        <= '0;
            row_q        <= '0;
            pre_q        <= '0;
            final_out_q  <= 1'b0;
            tag_short_q  <= 1'b0;
            tag_long_q   <= 1'b0;
            tag_fin_q    <= 1'b0;
            busy_q       <= 1'b0;
            inew_q       <= 1'b0;
            ivalid_q     <= 1'b0;
            idata_q      <= '0;
            frame_done_q <= 1'b0;
            err_cfg_q    <= 1'b0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            width_q      <= width_d;
            height_q     <= height_d;
            col_q        <= col_d;
            row_q        <= row_d;
            pre_q        <= pre_d;
            final_out_q  <= final_out_d;
            tag_short_q  <= tag_short_d;
            tag_long_q   <= tag_long_d;
            tag_fin_q    <= tag_fin_d;
            busy_q       <= busy_d;
            inew_q       <= inew_d;
            ivalid_q     <= ivalid_d;
            idata_q      <= idata_d;
            frame_done_q <= frame_done_d;
            err_cfg_q    <= err_cfg_d;
            err_short_q  <= err_short_d;
            err_long_q   <= err_long_d;
        end
    end

    assign busy       = busy_q;
    assign inew       = inew_q;
    assign ivalid     = ivalid_q;
    assign idata      = idata_q;
    assign frame_done = frame_done_q;
    assign err_cfg    = err_cfg_q;
    assign err_short  = err_short_q;
    assign err_long   = err_long_q;

endmodule

// File: doc/jls_stream_feeder.md
Name: jls_stream_feeder

Overview:
- Synthesizable front-end that converts a ready/valid pixel stream into the inew/ivalid/idata sequence the jls_encoder core consumes.
- It accepts CHANNELS pixels per input beat and serializes them to one pixel per clock.
- It emits the inew preamble, counts pixels against the configured frame size, and pads short frames or discards the excess of long frames, so the encoder always receives exactly width*height pixels.
- It sits between the pixel source (DMA/sensor) and jls_encoder.

Parameters:
- MAXLEN_LEVEL, 12, width-counter bits; max frame width (1<<MAXLEN_LEVEL)-1.
- DATA_W, 8, pixel bits (8..16).
- CHANNELS, 1, pixels per input beat (1..4); lane 0 = earliest pixel, in the LSBs.
- NEW_CYCLES, 368, cycles inew is held high before the first pixel.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; latches cfg_width/cfg_height, begins a frame. Ignored while busy.
- cfg_width  in  MAXLEN_LEVEL  frame width.
- cfg_height  in  16  frame height.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid&s_ready.
- s_data  in  CHANNELS*DATA_W  packed pixels.
- s_last  in  1  beat carries the frame's final pixel.
- busy  out  1  high from accepted start until frame_done.
- inew  out  1  to encoder.
- ivalid  out  1  to encoder.
- idata  out  DATA_W  to encoder.
- frame_done  out  1  one-cycle pulse after the final pixel is issued.
- err_cfg  out  1  one-cycle pulse: start rejected.
- err_short  out  1  one-cycle pulse: s_last arrived early.
- err_long  out  1  one-cycle pulse: frame count reached without s_last.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset is asynchronous and may be asserted mid-frame. No partial frame resumes after reset.
- All encoder-side outputs are registered. idata is 0 whenever ivalid=0.
- IDLE:
  - start with cfg_width<4 or cfg_height==0: err_cfg pulse next cycle, remain IDLE.
  - Valid start: latch the config and go to PREAMBLE.
  - s_ready=0 in IDLE.
- PREAMBLE: inew=1, ivalid=0 for exactly NEW_CYCLES cycles, then STREAM. s_ready=0.
- STREAM:
  - Beat register plus lane index.
  - s_ready = register empty OR the last used lane is issuing this cycle. This gives zero-bubble throughput of 1 pixel/clk.
  - A beat accepted in cycle t issues lane 0 with ivalid=1 in cycle t+1, then lanes 1..CHANNELS-1 on consecutive cycles.
  - Input starvation gives ivalid=0, inew=0 idle cycles.
- Counting: column counter 0..width-1 and row counter 0..height-1 (no multiplier). The final pixel is col=width-1, row=height-1. Lanes of the final beat beyond the final pixel are dropped.
- Short frame: s_last accepted before the final pixel.
  - err_short pulses on acceptance.
  - After the beat's lanes are issued, state PAD issues zero pixels, ivalid=1, one per clk, until the final pixel. s_ready=0 during PAD.
- Long frame: the final pixel lies in a beat without s_last.
  - err_long pulses on acceptance of that beat.
  - After that beat's lanes are issued, state DISCARD holds s_ready=1 and ivalid=0, and drops beats up to and including s_last.
- DONE: one cycle after the final pixel is issued, frame_done=1, busy=0 next, state IDLE. A start in the DONE cycle is ignored.
- s_valid/s_data/s_last while not in STREAM/DISCARD are ignored. The source must hold them stable until accepted.

Decomposition:
- Package jls_pkg holds:
  - constant JLS_MIN_WIDTH=4;
  - enum feeder_state_t {IDLE, PREAMBLE, STREAM, PAD, DISCARD, DONE};
  - default NEW_CYCLES.
- Sub-module jls_lane_serializer: beat register, lane index, used-lane limit, and the ready/valid handshake. The top holds the FSM, the preamble counter and the column/row counters.

Test Plan:
- CHANNELS=1, 4x2, start, 8 back-to-back beats 0x10..0x17, s_last on the 8th -> exactly 368 cycles inew=1, then ivalid=1 for 8 cycles with idata 0x10..0x17. frame_done pulses once. No error pulses.
- CHANNELS=4, 5x3 (15 pixels), 4 beats, lane 3 of the last beat=0xFF -> 15 consecutive ivalid cycles. s_ready high 1 cycle in 4. 0xFF never appears on idata.
- Short: CHANNELS=1, 4x4, s_last on beat 10 -> err_short pulse, then 6 cycles of ivalid=1 with idata=0. 16 total ivalid cycles, then frame_done.
- Long: CHANNELS=1, 4x2, 11 beats with s_last on 11 -> err_long pulse at beat 8. Beats 9-11 are accepted with ivalid=0. frame_done follows the s_last acceptance.
- cfg_width=3 (also cfg_height=0) -> err_cfg pulse, inew stays 0, busy=0, s_ready=0.
- rst_n low mid-STREAM -> all outputs 0 asynchronously. After release, a new 4x2 frame completes normally with a full 368-cycle preamble.
